// File: rtl/rssi_arb_pkg.sv
// Shared types and default widths for the RSSI dB converter arbiter.
// Optional drop counter build macro: RSSI_ARB_DROP_CNT_EN.
package rssi_arb_pkg;

    localparam int DEF_NUM_CH                = 2;
    localparam int DEF_IQ_DATA_WIDTH         = 16;
    localparam int DEF_IQ_RSSI_HALF_DB_WIDTH = 9;
    localparam int DEF_CONV_TIMEOUT          = 15;
    localparam int DROP_CNT_W                = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rssi_db_conv_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo NUM_CH.
module rr_pick
    import rssi_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PTR_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [PTR_W-1:0]  gnt_idx_o,
    output logic              gnt_any_o
);

    always_comb begin
        int j;
        j         = 0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (int'(ptr_i) + i) % NUM_CH;
            if (!gnt_any_o && req_i[j]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/rssi_db_conv_arbiter.sv
// Shares one iq_rssi_to_db converter among NUM_CH RSSI requesters, round-robin.
// Define RSSI_ARB_DROP_CNT_EN to add the per-channel overwrite counter output drop_cnt.
module rssi_db_conv_arbiter
    import rssi_arb_pkg::*;
#(
    parameter int NUM_CH                = DEF_NUM_CH,
    parameter int IQ_DATA_WIDTH         = DEF_IQ_DATA_WIDTH,
    parameter int IQ_RSSI_HALF_DB_WIDTH = DEF_IQ_RSSI_HALF_DB_WIDTH,
    parameter int CONV_TIMEOUT          = DEF_CONV_TIMEOUT
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NUM_CH*IQ_DATA_WIDTH-1:0]         ch_iq_rssi,
    input  logic [NUM_CH-1:0]                       ch_iq_rssi_valid,
    output logic [IQ_DATA_WIDTH-1:0]                conv_iq_rssi,
    output logic                                    conv_iq_rssi_valid,
    input  logic [IQ_RSSI_HALF_DB_WIDTH-1:0]        conv_iq_rssi_half_db,
    input  logic                                    conv_iq_rssi_half_db_valid,
    output logic [NUM_CH*IQ_RSSI_HALF_DB_WIDTH-1:0] ch_half_db,
    output logic [NUM_CH-1:0]                       ch_half_db_valid,
    output logic                                    busy,
    output logic                                    timeout_err
`ifdef RSSI_ARB_DROP_CNT_EN
    ,
    output logic [NUM_CH*DROP_CNT_W-1:0]            drop_cnt
`endif
);

    localparam int PTR_W = idx_w(NUM_CH);
    localparam int TMO_W = idx_w(CONV_TIMEOUT);

    logic [NUM_CH-1:0][IQ_DATA_WIDTH-1:0] ch_in;
    assign ch_in = ch_iq_rssi;

    arb_state_e                                   state_q, state_d;
    logic [NUM_CH-1:0]                            pend_q, pend_d;
    logic [NUM_CH-1:0][IQ_DATA_WIDTH-1:0]         pend_data_q, pend_data_d;
    logic [PTR_W-1:0]                             rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                             sel_q, sel_d;
    logic [TMO_W-1:0]                             tmo_q, tmo_d;
    logic [IQ_DATA_WIDTH-1:0]                     conv_q, conv_d;
    logic                                         conv_vld_q, conv_vld_d;
    logic [NUM_CH-1:0][IQ_RSSI_HALF_DB_WIDTH-1:0] res_q, res_d;
    logic [NUM_CH-1:0]                            res_vld_q, res_vld_d;
    logic                                         tmo_err_q, tmo_err_d;

    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [PTR_W-1:0] sel_nxt;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr_pick (
        .req_i     (pend_q),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign sel_nxt = (sel_q == PTR_W'(NUM_CH - 1)) ? '0 : sel_q + PTR_W'(1);

    // Clear on issue first so a same-cycle arrival for sel re-arms the slot.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (state_q == ST_ISSUE) begin
            pend_d[sel_q] = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_iq_rssi_valid[k]) begin
                pend_d[k]      = 1'b1;
                pend_data_d[k] = ch_in[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        tmo_d      = tmo_q;
        conv_d     = conv_q;
        conv_vld_d = 1'b0;
        res_d      = res_q;
        res_vld_d  = '0;
        tmo_err_d  = tmo_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    sel_d   = gnt_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                conv_d     = pend_data_q[sel_q];
                conv_vld_d = 1'b1;
                tmo_d      = TMO_W'(CONV_TIMEOUT - 1);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_iq_rssi_half_db_valid) begin
                    res_d[sel_q]     = conv_iq_rssi_half_db;
                    res_vld_d[sel_q] = 1'b1;
                    rr_ptr_d         = sel_nxt;
                    state_d          = ST_IDLE;
                end else if (tmo_q == '0) begin
                    tmo_err_d = 1'b1;
                    rr_ptr_d  = sel_nxt;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            pend_data_q <= '0;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            tmo_q       <= '0;
            conv_q      <= '0;
            conv_vld_q  <= 1'b0;
            res_q       <= '0;
            res_vld_q   <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            tmo_q       <= tmo_d;
            conv_q      <= conv_d;
            conv_vld_q  <= conv_vld_d;
            res_q       <= res_d;
            res_vld_q   <= res_vld_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign conv_iq_rssi       = conv_q;
    assign conv_iq_rssi_valid = conv_vld_q;
    assign ch_half_db         = res_q;
    assign ch_half_db_valid   = res_vld_q;
    assign busy               = (state_q != ST_IDLE);
    assign timeout_err        = tmo_err_q;

`ifdef RSSI_ARB_DROP_CNT_EN
    logic [NUM_CH-1:0][DROP_CNT_W-1:0] drop_q, drop_d;

    // A write into a slot already being issued this cycle is not a loss.
    always_comb begin
        drop_d = drop_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_iq_rssi_valid[k] && pend_q[k] &&
                !(state_q == ST_ISSUE && sel_q == PTR_W'(k)) &&
                (drop_q[k] != '1)) begin
                drop_d[k] = drop_q[k] + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_rssi_db_conv_arbiter.sv
// Directed bench for rssi_db_conv_arbiter with a 5-cycle converter model and a scoreboard monitor.
module tb_rssi_db_conv_arbiter;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int HW  = 9;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH*DW-1:0] ch_iq_rssi = '0;
    logic [NCH-1:0]    ch_iq_rssi_valid = '0;
    logic [DW-1:0]     conv_iq_rssi;
    logic              conv_iq_rssi_valid;
    logic [HW-1:0]     conv_iq_rssi_half_db;
    logic              conv_iq_rssi_half_db_valid;
    logic [NCH*HW-1:0] ch_half_db;
    logic [NCH-1:0]    ch_half_db_valid;
    logic              busy;
    logic              timeout_err;
`ifdef RSSI_ARB_DROP_CNT_EN
    logic [NCH*8-1:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    rssi_db_conv_arbiter #(
        .NUM_CH                (NCH),
        .IQ_DATA_WIDTH         (DW),
        .IQ_RSSI_HALF_DB_WIDTH (HW),
        .CONV_TIMEOUT          (15)
    ) dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .ch_iq_rssi                 (ch_iq_rssi),
        .ch_iq_rssi_valid           (ch_iq_rssi_valid),
        .conv_iq_rssi               (conv_iq_rssi),
        .conv_iq_rssi_valid         (conv_iq_rssi_valid),
        .conv_iq_rssi_half_db       (conv_iq_rssi_half_db),
        .conv_iq_rssi_half_db_valid (conv_iq_rssi_half_db_valid),
        .ch_half_db                 (ch_half_db),
        .ch_half_db_valid           (ch_half_db_valid),
        .busy                       (busy),
        .timeout_err                (timeout_err)
`ifdef RSSI_ARB_DROP_CNT_EN
        ,
        .drop_cnt                   (drop_cnt)
`endif
    );

    // Converter model: 5-cycle pipeline; conv_en low swallows the request.
    function automatic logic [HW-1:0] to_half_db(input logic [DW-1:0] x);
        case (x)
            16'd100: return 9'd90;
            16'd200: return 9'd102;
            default: return '0;
        endcase
    endfunction

    logic [4:0]         cv_pipe = '0;
    logic [4:0][HW-1:0] cd_pipe = '0;
    bit                 conv_en = 1'b1;
    int                 cyc = 0;

    always @(posedge clk) begin
        cv_pipe <= {cv_pipe[3:0], conv_iq_rssi_valid & conv_en};
        cd_pipe <= {cd_pipe[3:0], to_half_db(conv_iq_rssi)};
        cyc     <= cyc + 1;
    end

    assign conv_iq_rssi_half_db_valid = cv_pipe[4];
    assign conv_iq_rssi_half_db       = cd_pipe[4];

    typedef struct { int ch; int val; } res_t;
    res_t exp_res[$];
    int   exp_iss[$];
    int   checks = 0;
    int   errors = 0;
    int   last_iss = -100;
    int   prev_iss = -100;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input longint act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d with nothing expected", name, act);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        res_t r;
        if (rstn) begin
            if (conv_iq_rssi_valid) begin
                if (exp_iss.size() == 0) flag("unexpected_issue", conv_iq_rssi);
                else chk("issue_value", conv_iq_rssi, exp_iss.pop_front());
                prev_iss = last_iss;
                last_iss = cyc;
            end
            for (int k = 0; k < NCH; k++) begin
                if (ch_half_db_valid[k]) begin
                    if (exp_res.size() == 0) begin
                        flag("unexpected_result", k);
                    end else begin
                        r = exp_res.pop_front();
                        chk("result_ch", k, r.ch);
                        chk("result_val", ch_half_db[k*HW +: HW], r.val);
                        chk("latency", cyc - last_iss, 6);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [DW-1:0] v);
        @(negedge clk);
        ch_iq_rssi[ch*DW +: DW] = v;
        ch_iq_rssi_valid        = '0;
        ch_iq_rssi_valid[ch]    = 1'b1;
        @(negedge clk);
        ch_iq_rssi_valid = '0;
    endtask

    task automatic send_both(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        @(negedge clk);
        ch_iq_rssi       = {v1, v0};
        ch_iq_rssi_valid = 2'b11;
        @(negedge clk);
        ch_iq_rssi_valid = '0;
    endtask

    task automatic wait_issue(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (conv_iq_rssi_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no issue strobe within 50 cycles", name);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk({tag, "_conv_iq_rssi"}, conv_iq_rssi, 0);
        chk({tag, "_conv_valid"}, conv_iq_rssi_valid, 0);
        chk({tag, "_ch_half_db"}, ch_half_db, 0);
        chk({tag, "_ch_half_db_valid"}, ch_half_db_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
`ifdef RSSI_ARB_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(2);
        do_reset("rst0");

        // Single sample on ch0
        exp_iss.push_back(100);
        exp_res.push_back('{0, 90});
        send(0, 16'd100);
        wait_issue("t1");
        chk("t1_busy", busy, 1);
        idle(20);
        chk("t1_hold", ch_half_db[0 +: HW], 90);
        chk("t1_idle", busy, 0);

        // Simultaneous strobes from a clean pointer
        do_reset("rst1");
        exp_iss.push_back(100); exp_res.push_back('{0, 90});
        exp_iss.push_back(100); exp_res.push_back('{1, 90});
        send_both(16'd100, 16'd100);
        idle(30);
        chk("t2_gap", last_iss - prev_iss, 8);
        chk("t2_ch1_hold", ch_half_db[HW +: HW], 90);

        // Pointer must be back on ch0
        exp_iss.push_back(100); exp_res.push_back('{0, 90});
        exp_iss.push_back(200); exp_res.push_back('{1, 102});
        send_both(16'd100, 16'd200);
        idle(30);

        // Overwrite of ch1 while ch0 waits
        exp_iss.push_back(100); exp_res.push_back('{0, 90});
        exp_iss.push_back(100); exp_res.push_back('{1, 90});
        send(0, 16'd100);
        wait_issue("t3");
        send(1, 16'd200);
        send(1, 16'd100);
        idle(30);
`ifdef RSSI_ARB_DROP_CNT_EN
        chk("t3_drop_cnt1", drop_cnt[15:8], 1);
        chk("t3_drop_cnt0", drop_cnt[7:0], 0);
`endif

        // Converter silent for ch0; ch1 still served afterwards
        chk("t4_err_clear", timeout_err, 0);
        conv_en = 1'b0;
        exp_iss.push_back(100);
        exp_iss.push_back(200); exp_res.push_back('{1, 102});
        send_both(16'd100, 16'd200);
        wait_issue("t4");
        idle(14);
        chk("t4_tmo_early", timeout_err, 0);
        idle(1);
        chk("t4_tmo_set", timeout_err, 1);
        conv_en = 1'b1;
        idle(30);
        chk("t4_tmo_sticky", timeout_err, 1);
        chk("t4_ch0_untouched", ch_half_db[0 +: HW], 90);

        // Reset during WAIT; late converter strobe must be ignored
        exp_iss.push_back(100);
        send(0, 16'd100);
        wait_issue("t5");
        idle(2);
        do_reset("rst_mid");
        idle(20);
        chk("t5_no_result", ch_half_db, 0);
        chk("t5_idle", busy, 0);

        chk("iss_queue_empty", exp_iss.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
